// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request ports of both clients plus the shared data-memory bus
interface mem_port_arbiter_if;
   logic        p0_req, p1_req, p0_we, p1_we;
   logic [1:0]  p0_load_mode, p1_load_mode, mem_load_mode;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic        p0_done, p1_done, p0_err, p1_err, stall;
   logic [31:0] rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_load_mode, p1_load_mode,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_read_data,
      output p0_done, p1_done, p0_err, p1_err, stall, rdata,
             mem_read, mem_write, mem_load_mode, mem_address, mem_write_data
   );
   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_load_mode, p1_load_mode,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_read_data,
      input  p0_done, p1_done, p0_err, p1_err, stall, rdata,
             mem_read, mem_write, mem_load_mode, mem_address, mem_write_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency data memory between two ports, port 0 first with a starvation bound
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int MAX_CONSEC  = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LATENCY + 1);
   localparam int KW = $clog2(MAX_CONSEC + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LATENCY - 1);
   localparam logic [KW-1:0] KMAX = KW'(MAX_CONSEC);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [KW-1:0] consec;
   logic win, any_req, sel_we, sel_bad, win_q, we_q, err_q;
   logic [1:0] sel_mode, mode_q;
   logic [31:0] sel_addr, sel_wdata, addr_q, wdata_q, rdata_q;
   // winner selection, alignment check and next state
   always_comb begin
      win       = bus.p1_req & (~bus.p0_req | consec == KMAX);
      any_req   = bus.p0_req | bus.p1_req;
      sel_we    = win ? bus.p1_we : bus.p0_we;
      sel_mode  = win ? bus.p1_load_mode : bus.p0_load_mode;
      sel_addr  = win ? bus.p1_addr : bus.p0_addr;
      sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
      sel_bad   = (&sel_mode) | (sel_mode == 2'b00 & |sel_addr[1:0]) | (sel_mode == 2'b01 & sel_addr[0]);
      state_n   = state == IDLE   ? (any_req ? (sel_bad ? RESP : ACCESS) : IDLE) :
                  state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   // grant latch, latency counter, load capture and port-0 streak counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt     <= '0;
         consec  <= '0;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            win_q   <= win;
            we_q    <= sel_we;
            err_q   <= sel_bad;
            mode_q  <= sel_mode;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= LAT_M1;
         end else if (state == ACCESS) cnt <= cnt - 1'b1;
         if (state == ACCESS && cnt == '0 && !we_q) rdata_q <= bus.mem_read_data;
         if (state == IDLE) consec <= (!bus.p1_req || win) ? '0 : consec != KMAX ? consec + 1'b1 : consec;
      end
   assign bus.mem_read       = state == ACCESS & ~we_q;
   assign bus.mem_write      = state == ACCESS & we_q;
   assign bus.mem_load_mode  = mode_q;
   assign bus.mem_address    = addr_q;
   assign bus.mem_write_data = wdata_q;
   assign bus.p0_done        = state == RESP & ~win_q;
   assign bus.p1_done        = state == RESP & win_q;
   assign bus.p0_err         = bus.p0_done & err_q;
   assign bus.p1_err         = bus.p1_done & err_q;
   assign bus.rdata          = rdata_q;
   assign bus.stall          = bus.p0_req & ~bus.p0_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests against a cycle-arithmetic model of the arbiter
module tb_mem_port_arbiter;
   localparam int LAT = 2;
   localparam int MAXC = 4;
   logic clk, rst_n;
   int cyc = 0;
   int checks = 0, failures = 0;
   mem_port_arbiter_if bus();
   mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_CONSEC(MAXC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit rejected(input logic [1:0] mode, input logic [31:0] addr);
      return mode == 2'd3 || (mode == 2'd0 && addr % 4 != 0) || (mode == 2'd1 && addr % 2 != 0);
   endfunction

   // model: one transaction at a time, timed by its grant cycle
   bit m_act = 0, m_win = 0, m_we = 0, m_bad = 0;
   int m_g = 0, m_consec = 0, m_done_cyc;
   logic [1:0] m_mode = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
   bit e_strobe, e_d0, e_d1;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_act = 0;
         m_consec = 0;
         m_rdata = 0;
         chk("rst_mem_read", 32'(bus.mem_read), 0);
         chk("rst_mem_write", 32'(bus.mem_write), 0);
         chk("rst_p0_done", 32'(bus.p0_done), 0);
         chk("rst_p1_done", 32'(bus.p1_done), 0);
         chk("rst_rdata", bus.rdata, 0);
         chk("rst_mem_address", bus.mem_address, 0);
         chk("rst_stall", 32'(bus.stall), 32'(bus.p0_req));
      end else begin
         m_done_cyc = m_bad ? m_g : m_g + LAT;
         e_strobe = m_act && !m_bad && cyc >= m_g && cyc < m_g + LAT;
         e_d0 = m_act && cyc == m_done_cyc && !m_win;
         e_d1 = m_act && cyc == m_done_cyc && m_win;
         chk("mem_read", 32'(bus.mem_read), 32'(e_strobe && !m_we));
         chk("mem_write", 32'(bus.mem_write), 32'(e_strobe && m_we));
         chk("p0_done", 32'(bus.p0_done), 32'(e_d0));
         chk("p1_done", 32'(bus.p1_done), 32'(e_d1));
         chk("p0_err", 32'(bus.p0_err), 32'(e_d0 && m_bad));
         chk("p1_err", 32'(bus.p1_err), 32'(e_d1 && m_bad));
         chk("rdata", bus.rdata, m_rdata);
         chk("stall", 32'(bus.stall), 32'(bus.p0_req && !e_d0));
         if (e_strobe) begin
            chk("mem_address", bus.mem_address, m_addr);
            chk("mem_write_data", bus.mem_write_data, m_wdata);
            chk("mem_load_mode", 32'(bus.mem_load_mode), 32'(m_mode));
         end
         if (m_act && !m_bad && !m_we && cyc == m_g + LAT - 1) m_rdata = bus.mem_read_data;
         if (m_act) begin
            if (cyc == m_done_cyc) m_act = 0;
         end else if (bus.p0_req || bus.p1_req) begin
            m_win = bus.p1_req && (!bus.p0_req || m_consec == MAXC);
            if (!bus.p1_req || m_win) m_consec = 0;
            else if (m_consec < MAXC) m_consec++;
            m_we = m_win ? bus.p1_we : bus.p0_we;
            m_mode = m_win ? bus.p1_load_mode : bus.p0_load_mode;
            m_addr = m_win ? bus.p1_addr : bus.p0_addr;
            m_wdata = m_win ? bus.p1_wdata : bus.p0_wdata;
            m_bad = rejected(m_mode, m_addr);
            m_g = cyc + 1;
            m_act = 1;
         end else m_consec = 0;
      end
   end

   // observed activity, checked against hand-computed literals
   int rd_cnt, wr_cnt, first_strobe;
   logic [1:0] mon_mode;
   logic [31:0] mon_addr, mon_wdata;
   int done_log[$];
   always @(negedge clk) begin
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) wr_cnt++;
      if ((bus.mem_read || bus.mem_write) && first_strobe < 0) begin
         first_strobe = cyc;
         mon_mode = bus.mem_load_mode;
         mon_addr = bus.mem_address;
         mon_wdata = bus.mem_write_data;
      end
      if (bus.p0_done) done_log.push_back(0);
      if (bus.p1_done) done_log.push_back(1);
   end

   task automatic clear_mon();
      rd_cnt = 0;
      wr_cnt = 0;
      first_strobe = -1;
   endtask

   task automatic req(input bit port, input bit we, input logic [1:0] mode, input logic [31:0] addr,
                      input logic [31:0] wdata, output int k);
      @(posedge clk);
      #1;
      if (port) begin
         bus.p1_we = we; bus.p1_load_mode = mode; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1;
      end else begin
         bus.p0_we = we; bus.p0_load_mode = mode; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1;
      end
      k = cyc;
   endtask

   task automatic wait_done(input bit port, output int dc);
      int n = 0;
      dc = -1;
      while (n < 40) begin
         @(negedge clk);
         if (port ? bus.p1_done : bus.p0_done) begin
            dc = cyc;
            break;
         end
         n++;
      end
      if (dc < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic drop(input bit port);
      @(posedge clk);
      #1;
      if (port) bus.p1_req = 0;
      else bus.p0_req = 0;
   endtask

   int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      int k, dc, dc2, r, n, nd;
      rst_n = 0;
      bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
      bus.p0_load_mode = 0; bus.p1_load_mode = 0; bus.p0_addr = 0; bus.p1_addr = 0;
      bus.p0_wdata = 0; bus.p1_wdata = 0; bus.mem_read_data = 0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdata", bus.rdata, 0);
      chk("reset_strobes", 32'(bus.mem_read | bus.mem_write), 0);
      rst_n = 1;

      bus.mem_read_data = 32'hDEADBEEF;
      clear_mon();
      req(0, 0, 2'b00, 32'h10, 0, k);
      wait_done(0, dc);
      chk("load_done_cycle", dc, k + 3);
      chk("load_first_strobe", first_strobe, k + 1);
      chk("load_read_cycles", rd_cnt, 2);
      chk("load_write_cycles", wr_cnt, 0);
      chk("load_address", mon_addr, 32'h10);
      chk("load_rdata", bus.rdata, 32'hDEADBEEF);
      chk("load_stall_at_done", 32'(bus.stall), 0);
      drop(0);

      bus.mem_read_data = 32'h12345678;
      clear_mon();
      req(1, 1, 2'b10, 32'h23, 32'hAB, k);
      wait_done(1, dc);
      chk("store_done_cycle", dc, k + 3);
      chk("store_write_cycles", wr_cnt, 2);
      chk("store_read_cycles", rd_cnt, 0);
      chk("store_mode", 32'(mon_mode), 2);
      chk("store_wdata", mon_wdata, 32'hAB);
      chk("store_rdata_kept", bus.rdata, 32'hDEADBEEF);
      drop(1);

      clear_mon();
      req(0, 0, 2'b00, 32'h6, 0, k);
      wait_done(0, dc);
      chk("misaligned_done_cycle", dc, k + 1);
      chk("misaligned_err", 32'(bus.p0_err), 1);
      chk("misaligned_strobes", rd_cnt + wr_cnt, 0);
      drop(0);
      clear_mon();
      req(0, 1, 2'b11, 32'h0, 32'h55, k);
      wait_done(0, dc);
      chk("reserved_done_cycle", dc, k + 1);
      chk("reserved_err", 32'(bus.p0_err), 1);
      chk("reserved_strobes", rd_cnt + wr_cnt, 0);
      chk("reserved_rdata_kept", bus.rdata, 32'hDEADBEEF);
      drop(0);
      bus.mem_read_data = 32'h0000CAFE;
      clear_mon();
      req(0, 0, 2'b01, 32'h2, 0, k);
      wait_done(0, dc);
      chk("half_ok_err", 32'(bus.p0_err), 0);
      chk("half_ok_rdata", bus.rdata, 32'h0000CAFE);
      drop(0);

      bus.mem_read_data = 32'h11111111;
      clear_mon();
      req(0, 0, 2'b00, 32'h40, 0, k);
      wait_done(0, dc);
      first_strobe = -1;
      wait_done(0, dc2);
      chk("b2b_first_done", dc, k + 3);
      chk("b2b_second_done", dc2, dc + 4);
      chk("b2b_second_strobe", first_strobe, dc + 2);
      chk("b2b_read_cycles", rd_cnt, 4);
      drop(0);

      bus.mem_read_data = 32'h77777777;
      req(0, 0, 2'b00, 32'h80, 0, k);
      n = 0;
      while (!bus.mem_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_strobe_seen", 32'(bus.mem_read), 1);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("rst_mid_read_drop", 32'(bus.mem_read), 0);
      chk("rst_mid_no_done", 32'(bus.p0_done), 0);
      chk("rst_mid_rdata", bus.rdata, 0);
      nd = done_log.size();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      r = cyc;
      wait_done(0, dc);
      chk("rst_regrant_done", dc, r + 3);
      chk("rst_regrant_rdata", bus.rdata, 32'h77777777);
      drop(0);
      chk("rst_done_count", done_log.size(), nd + 1);

      @(posedge clk);
      #1;
      rst_n = 0;
      bus.mem_read_data = 32'h5A5A5A5A;
      bus.p0_we = 0; bus.p0_load_mode = 0; bus.p0_addr = 32'h100;
      bus.p1_we = 0; bus.p1_load_mode = 0; bus.p1_addr = 32'h200;
      bus.p0_req = 1;
      bus.p1_req = 1;
      done_log.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      n = 0;
      while (done_log.size() < 10 && n < 80) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) chk("grant_order", i < done_log.size() ? done_log[i] : 99, exp_order[i]);
      @(posedge clk);
      #1;
      bus.p0_req = 0;
      bus.p1_req = 0;
      repeat (8) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
